// File: rtl/ysyx_23060332_core_ctrl.sv
// Multi-cycle core sequencer: fetch handshake, one-cycle decode/execute, optional
// data-memory handshake, one-cycle writeback, and a sticky halt on ebreak/invalid.
module ysyx_23060332_core_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] pc,
    output logic [31:0] inst_o,
    input  logic [31:0] dnpc_i,
    input  logic        is_mem_i,
    input  logic        halt_i,
    input  logic        invalid_i,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        rf_wen_gate,
    output logic        halted,
    output logic        trap_invalid,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        MEM_REQ    = 3'd3,
        MEM_WAIT   = 3'd4,
        WB         = 3'd5,
        HALT       = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q;
    logic        trap_q, trap_d;
    logic        ifu_req_raw;
    logic        lsu_req_d;
    logic        wen_d;
    logic        retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            trap_q  <= trap_d;
        end
    end

    // Retire counter only moves on writeback; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        trap_d      = trap_q;
        ifu_req_raw = 1'b0;
        lsu_req_d   = 1'b0;
        wen_d       = 1'b0;
        retire      = 1'b0;
        case (state_q)
            FETCH_REQ: begin
                ifu_req_raw = 1'b1;
                if (ifu_req_ready) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (ifu_rsp_valid) begin
                    inst_d  = ifu_rsp_inst;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (halt_i) begin
                    trap_d  = 1'b0;
                    state_d = HALT;
                end else if (invalid_i) begin
                    trap_d  = 1'b1;
                    state_d = HALT;
                end else if (is_mem_i) begin
                    state_d = MEM_REQ;
                end else begin
                    state_d = WB;
                end
            end
            MEM_REQ: begin
                lsu_req_d = 1'b1;
                if (lsu_req_ready) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (lsu_rsp_valid) state_d = WB;
            end
            WB: begin
                wen_d   = 1'b1;
                retire  = 1'b1;
                pc_d    = dnpc_i;
                state_d = FETCH_REQ;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase
    end

    // State already sits in FETCH_REQ during reset, so the request must be masked.
    assign ifu_req_valid = ifu_req_raw & ~rst;
    assign lsu_req_valid = lsu_req_d;
    assign rf_wen_gate   = wen_d;
    assign pc            = pc_q;
    assign inst_o        = inst_q;
    assign instret       = instret_q;
    assign halted        = (state_q == HALT);
    assign trap_invalid  = trap_q;

endmodule

// File: tb/tb_ysyx_23060332_core_ctrl.sv
// Directed bench for ysyx_23060332_core_ctrl: reset, ALU and load flows, halt paths,
// reset abort of a pending fetch, and instret wrap.
module tb_ysyx_23060332_core_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic [31:0] pc;
    logic [31:0] inst_o;
    logic [31:0] dnpc_i;
    logic        is_mem_i;
    logic        halt_i;
    logic        invalid_i;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        rf_wen_gate;
    logic        halted;
    logic        trap_invalid;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_err = 0;
    int c_ifu = 0;
    int c_lsu = 0;
    int c_wen = 0;
    int c_both = 0;

    always #5 clk = ~clk;

    ysyx_23060332_core_ctrl #(
        .RESET_PC (32'h8000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .pc            (pc),
        .inst_o        (inst_o),
        .dnpc_i        (dnpc_i),
        .is_mem_i      (is_mem_i),
        .halt_i        (halt_i),
        .invalid_i     (invalid_i),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rf_wen_gate   (rf_wen_gate),
        .halted        (halted),
        .trap_invalid  (trap_invalid),
        .instret       (instret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and tally the outputs seen in that cycle.
    task automatic tick();
        @(negedge clk);
        if (ifu_req_valid) c_ifu++;
        if (lsu_req_valid) c_lsu++;
        if (rf_wen_gate) c_wen++;
        if (ifu_req_valid && lsu_req_valid) c_both++;
    endtask

    task automatic clr();
        c_ifu = 0;
        c_lsu = 0;
        c_wen = 0;
    endtask

    initial begin
        rst           = 1'b1;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        dnpc_i        = '0;
        is_mem_i      = 1'b0;
        halt_i        = 1'b0;
        invalid_i     = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        tick();
        tick();

        check("rst_ifu_valid", {31'd0, ifu_req_valid}, 32'd0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst_o, 32'h0000_0013);
        check("rst_instret", instret, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_trap", {31'd0, trap_invalid}, 32'd0);
        check("rst_wen", {31'd0, rf_wen_gate}, 32'd0);
        check("rst_lsu_valid", {31'd0, lsu_req_valid}, 32'd0);

        // addi with immediate fetch handshake
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h0010_0093;
        dnpc_i        = 32'h8000_0004;
        rst           = 1'b0;
        #1;
        check("ifu_after_release", {31'd0, ifu_req_valid}, 32'd1);
        tick();
        check("fw_ifu_valid", {31'd0, ifu_req_valid}, 32'd0);
        tick();
        check("exec_inst", inst_o, 32'h0010_0093);
        check("exec_wen", {31'd0, rf_wen_gate}, 32'd0);
        tick();
        check("wb_wen_c4", {31'd0, rf_wen_gate}, 32'd1);
        check("wb_pc_old", pc, 32'h8000_0000);
        check("wb_instret_old", instret, 32'd0);
        tick();
        check("addi_pc", pc, 32'h8000_0004);
        check("addi_instret", instret, 32'd1);
        check("addi_wen_off", {31'd0, rf_wen_gate}, 32'd0);

        // load with delayed LSU handshakes and a stray early response
        ifu_rsp_inst = 32'h0000_2083;
        is_mem_i     = 1'b1;
        dnpc_i       = 32'h8000_0008;
        clr();
        tick();
        tick();
        tick();
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        tick();
        tick();
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        check("mw_lsu_valid", {31'd0, lsu_req_valid}, 32'd0);
        tick();
        tick();
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        is_mem_i      = 1'b0;
        check("ld_wb_wen", {31'd0, rf_wen_gate}, 32'd1);
        check("ld_lsu_cycles", c_lsu, 32'd4);
        check("ld_wen_pulses", c_wen, 32'd1);
        check("ld_no_fetch", c_ifu, 32'd0);
        tick();
        check("ld_pc", pc, 32'h8000_0008);
        check("ld_instret", instret, 32'd2);
        check("ld_refetch", {31'd0, ifu_req_valid}, 32'd1);

        // ebreak, with invalid_i also raised: halt must take priority
        ifu_rsp_inst = 32'h0010_0073;
        halt_i       = 1'b1;
        invalid_i    = 1'b1;
        dnpc_i       = 32'h8000_000C;
        tick();
        tick();
        tick();
        halt_i    = 1'b0;
        invalid_i = 1'b0;
        check("eb_halted", {31'd0, halted}, 32'd1);
        check("eb_trap", {31'd0, trap_invalid}, 32'd0);
        check("eb_instret", instret, 32'd2);
        check("eb_pc", pc, 32'h8000_0008);
        clr();
        repeat (5) tick();
        check("halt_no_ifu", c_ifu, 32'd0);
        check("halt_no_lsu", c_lsu, 32'd0);
        check("halt_no_wen", c_wen, 32'd0);
        check("halt_pc_frozen", pc, 32'h8000_0008);
        check("halt_inst_frozen", inst_o, 32'h0010_0073);
        check("halt_sticky", {31'd0, halted}, 32'd1);

        // asynchronous reset out of HALT, then an invalid instruction
        rst = 1'b1;
        #1;
        check("async_halted", {31'd0, halted}, 32'd0);
        check("async_pc", pc, 32'h8000_0000);
        check("async_inst", inst_o, 32'h0000_0013);
        check("async_instret", instret, 32'd0);
        tick();
        rst          = 1'b0;
        ifu_rsp_inst = 32'h0000_0000;
        invalid_i    = 1'b1;
        tick();
        tick();
        tick();
        invalid_i = 1'b0;
        check("inv_halted", {31'd0, halted}, 32'd1);
        check("inv_trap", {31'd0, trap_invalid}, 32'd1);
        check("inv_instret", instret, 32'd0);
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        ifu_rsp_valid = 1'b0;
        #1;
        check("inv_rst_pc", pc, 32'h8000_0000);
        check("inv_rst_trap", {31'd0, trap_invalid}, 32'd0);
        check("inv_rst_halted", {31'd0, halted}, 32'd0);
        check("inv_rst_fetch", {31'd0, ifu_req_valid}, 32'd1);
        tick();
        check("fw_pending", {31'd0, ifu_req_valid}, 32'd0);

        // reset while FETCH_WAIT; late response must be dropped
        rst          = 1'b1;
        ifu_rsp_inst = 32'hDEAD_BEEF;
        tick();
        rst           = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        tick();
        tick();
        check("abort_inst", inst_o, 32'h0000_0013);
        check("abort_instret", instret, 32'd0);
        check("abort_fetch_req", {31'd0, ifu_req_valid}, 32'd1);

        // instret wrap via backdoor preload, with an unaligned next PC
        dut.instret_q = 32'hFFFF_FFFF;
        #1;
        check("preload_instret", instret, 32'hFFFF_FFFF);
        ifu_req_ready = 1'b1;
        ifu_rsp_inst  = 32'h0010_0093;
        dnpc_i        = 32'h8000_0006;
        tick();
        tick();
        tick();
        tick();
        check("wrap_instret", instret, 32'd0);
        check("unaligned_pc", pc, 32'h8000_0006);
        check("never_both_req", c_both, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
